// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types, constants and the arbitration decision used by the dual
// master Wishbone arbiter.
//   arb_state_t : bus ownership state (IDLE, GNT0, GNT1)
//   PRIO_RR     : round-robin arbitration between the two masters
//   PRIO_FIXED  : fixed priority, master 1 always wins a tie
//   next_grant  : picks the owner for a given pair of requests
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // last_grant: 0 = m0 owned the bus last, 1 = m1 owned it last.
    // Returns IDLE when nobody is requesting.
    function automatic arb_state_t next_grant(
        input logic req0,
        input logic req1,
        input logic last_grant,
        input int   mode
    );
        arb_state_t result;
        result = IDLE;
        if (req0 && req1) begin
            if (mode == PRIO_FIXED) begin
                result = GNT1;
            end else begin
                // Round-robin: the master that did not own the bus last wins.
                result = last_grant ? GNT0 : GNT1;
            end
        end else if (req0) begin
            result = GNT0;
        end else if (req1) begin
            result = GNT1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
// Counts stalled bus cycles and flags when the limit is reached.
//   clk       : clock, all updates on rising edge
//   reset     : synchronous active-high reset, clears the count
//   i_enable  : one stalled cycle (strobe high, no ack) to count
//   i_clear   : restart the count (ack, termination, ownership change)
//   o_expired : count equals TIMEOUT_CYCLES; constant 0 when TIMEOUT_CYCLES = 0
// ---------------------------------------------------------------------------
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            // Watchdog switched off: inputs intentionally ignored.
            logic w_unused_inputs;
            assign w_unused_inputs = &{1'b0, clk, reset, i_enable, i_clear};
            assign o_expired = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

            logic [CW-1:0] r_count;

            always_ff @(posedge clk) begin
                if (reset || i_clear) begin
                    r_count <= '0;
                end else if (i_enable) begin
                    r_count <= r_count + CW'(1);
                end
            end

            // Once expired the top forces the strobe low, so enable drops and
            // the count never runs past the limit.
            assign o_expired = (r_count == CW'(TIMEOUT_CYCLES));
        end
    endgenerate

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_dual_master_arbiter
// Shares one Wishbone-style slave between m0 (instruction fetch) and m1
// (data access). Ownership is re-arbitrated at every transfer termination so
// masters holding cyc high permanently still share the bus. A watchdog ends
// stalled transfers with a one-cycle err pulse.
//   clk, reset           : clock and synchronous active-high reset
//   mN_cyc/stb/we        : master N transaction controls
//   mN_wstrb/addr/data_i : master N byte strobes, address, write data
//   mN_data_o            : read data to master N (0 unless it owns the bus)
//   mN_ack, mN_err       : master N termination
//   s_*                  : shared slave bus, driven by the current owner
//   s_data_i, s_ack      : slave read data and acknowledge
//   grant                : registered one-hot owner (bit0 m0, bit1 m1)
// ---------------------------------------------------------------------------
module wb_dual_master_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack,
    output logic                    m0_err,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack,
    output logic                    m1_err,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack,

    output logic [1:0]              grant
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_last_grant;
    logic       w_last_grant_next;

    logic w_req0;
    logic w_req1;
    logic w_expired;
    logic w_term;
    logic w_wd_enable;
    logic w_wd_clear;

    assign w_req0 = m0_cyc & m0_stb;
    assign w_req1 = m1_cyc & m1_stb;

    // A transfer ends on a slave ack or on a watchdog expiry; only meaningful
    // while a master owns the bus.
    assign w_term = s_ack | w_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // m0 wins the first tie
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;

        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_data_o  = '0;
        m0_data_o = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_data_o = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        grant     = 2'b00;

        case (r_state)
            IDLE: begin
                w_state_next = next_grant(w_req0, w_req1, r_last_grant, PRIORITY_MODE);
            end

            GNT0: begin
                grant     = 2'b01;
                s_cyc     = m0_cyc;
                s_stb     = m0_stb & ~w_expired;
                s_we      = m0_we;
                s_wstrb   = m0_wstrb;
                s_addr    = m0_addr;
                s_data_o  = m0_data_i;
                m0_data_o = s_data_i;
                m0_ack    = s_ack;
                m0_err    = w_expired;

                if (!m0_cyc) begin
                    w_state_next      = w_req1 ? GNT1 : IDLE;
                    w_last_grant_next = 1'b0;
                end else if (w_term &&
                             (next_grant(w_req0, w_req1, 1'b0, PRIORITY_MODE) == GNT1)) begin
                    // Arbitrate as if m0 just finished; stay put otherwise.
                    w_state_next      = GNT1;
                    w_last_grant_next = 1'b0;
                end
            end

            GNT1: begin
                grant     = 2'b10;
                s_cyc     = m1_cyc;
                s_stb     = m1_stb & ~w_expired;
                s_we      = m1_we;
                s_wstrb   = m1_wstrb;
                s_addr    = m1_addr;
                s_data_o  = m1_data_i;
                m1_data_o = s_data_i;
                m1_ack    = s_ack;
                m1_err    = w_expired;

                if (!m1_cyc) begin
                    w_state_next      = w_req0 ? GNT0 : IDLE;
                    w_last_grant_next = 1'b1;
                end else if (w_term &&
                             (next_grant(w_req0, w_req1, 1'b1, PRIORITY_MODE) == GNT0)) begin
                    w_state_next      = GNT0;
                    w_last_grant_next = 1'b1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Count only genuine stalls of the owning master; any termination or
    // ownership change restarts the watchdog.
    assign w_wd_enable = (r_state != IDLE) & s_stb & ~s_ack;
    assign w_wd_clear  = s_ack | w_expired | (w_state_next != r_state);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (w_wd_enable),
        .i_clear   (w_wd_clear),
        .o_expired (w_expired)
    );

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_dual_master_arbiter
// Drives two arbiter instances from shared master/slave stimulus:
//   dut    : round-robin, watchdog of 4 cycles
//   dut_fx : fixed priority (m1 wins), watchdog disabled
// Table-driven vectors cover round-robin alternation; hand-written sequences
// cover the read, fixed priority, timeout, write muxing and reset corners.
// ---------------------------------------------------------------------------
module tb_wb_dual_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_data_i;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_data_i;
    logic [31:0] s_data_i;
    logic        s_ack;

    // Round-robin instance outputs
    logic [31:0] m0_data_o, m1_data_o, s_addr, s_data_o;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    // Fixed-priority instance outputs
    logic [31:0] f_m0_data_o, f_m1_data_o, f_s_addr, f_s_data_o;
    logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
    logic        f_s_cyc, f_s_stb, f_s_we;
    logic [3:0]  f_s_wstrb;
    logic [1:0]  f_grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_dual_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack(s_ack),
        .grant(grant)
    );

    wb_dual_master_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_data_i(m0_data_i), .m0_data_o(f_m0_data_o),
        .m0_ack(f_m0_ack), .m0_err(f_m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_data_i(m1_data_i), .m1_data_o(f_m1_data_o),
        .m1_ack(f_m1_ack), .m1_err(f_m1_err),
        .s_cyc(f_s_cyc), .s_stb(f_s_stb), .s_we(f_s_we), .s_wstrb(f_s_wstrb),
        .s_addr(f_s_addr), .s_data_o(f_s_data_o), .s_data_i(s_data_i), .s_ack(s_ack),
        .grant(f_grant)
    );

    typedef struct {
        logic       m0_req;
        logic       m1_req;
        logic       ack;
        logic [1:0] exp_grant;
        logic       exp_m0_ack;
        logic       exp_m1_ack;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_wstrb = 4'hF;
        m0_addr = 32'h0; m0_data_i = 32'h0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_wstrb = 4'hF;
        m1_addr = 32'h0; m1_data_i = 32'h0;
        s_data_i = 32'h0; s_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // m0_req, m1_req, ack, grant, m0_ack, m1_ack
        vecs[0] = '{1, 1, 1, 2'b00, 0, 0};  // IDLE: arbitration cycle
        vecs[1] = '{1, 1, 1, 2'b01, 1, 0};  // m0 wins first tie
        vecs[2] = '{1, 1, 1, 2'b10, 0, 1};
        vecs[3] = '{1, 1, 1, 2'b01, 1, 0};
        vecs[4] = '{1, 1, 1, 2'b10, 0, 1};
        vecs[5] = '{1, 1, 0, 2'b01, 0, 0};  // no ack: m0 keeps the bus
        vecs[6] = '{1, 1, 1, 2'b01, 1, 0};
        vecs[7] = '{0, 0, 0, 2'b10, 0, 0};  // m1 drops cyc -> IDLE
        vecs[8] = '{0, 0, 0, 2'b00, 0, 0};

        reset = 1;
        clear_inputs();

        // ---- reset state ----
        do_reset();
        s_ack = 1; s_data_i = 32'hFFFF_FFFF;
        #1;
        check("reset_grant", {30'b0, grant}, 32'h0);
        check("reset_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'h0);
        check("reset_acks", {30'b0, m0_ack, m1_ack}, 32'h0);
        check("reset_m0_data_o", m0_data_o, 32'h0);
        check("reset_fx_grant", {30'b0, f_grant}, 32'h0);
        $display("txn reset grant=%b", grant);

        // ---- m0 read ----
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0010;
        #1;
        check("rd_idle_grant", {30'b0, grant}, 32'h0);
        check("rd_idle_s_stb", {31'b0, s_stb}, 32'h0);
        tick();
        check("rd_grant", {30'b0, grant}, 32'h1);
        check("rd_s_stb", {31'b0, s_stb}, 32'h1);
        check("rd_s_addr", s_addr, 32'h0000_0010);
        check("rd_s_we", {31'b0, s_we}, 32'h0);
        s_ack = 1; s_data_i = 32'hDEAD_BEEF;
        #1;
        check("rd_m0_ack", {31'b0, m0_ack}, 32'h1);
        check("rd_m0_data", m0_data_o, 32'hDEAD_BEEF);
        check("rd_m1_ack", {31'b0, m1_ack}, 32'h0);
        check("rd_m1_data", m1_data_o, 32'h0);
        $display("txn m0 read addr=%h data=%h ack=%b", s_addr, m0_data_o, m0_ack);
        tick();
        clear_inputs();

        // ---- round-robin table ----
        do_reset();
        for (int i = 0; i < 9; i++) begin
            m0_cyc = vecs[i].m0_req; m0_stb = vecs[i].m0_req;
            m1_cyc = vecs[i].m1_req; m1_stb = vecs[i].m1_req;
            s_ack  = vecs[i].ack;
            #1;
            check($sformatf("rr%0d_grant", i), {30'b0, grant}, {30'b0, vecs[i].exp_grant});
            check($sformatf("rr%0d_m0_ack", i), {31'b0, m0_ack}, {31'b0, vecs[i].exp_m0_ack});
            check($sformatf("rr%0d_m1_ack", i), {31'b0, m1_ack}, {31'b0, vecs[i].exp_m1_ack});
            $display("txn rr vec %0d grant=%b m0_ack=%b m1_ack=%b", i, grant, m0_ack, m1_ack);
            tick();
        end

        // ---- fixed priority: m1 holds the bus, m0 starves ----
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
        #1;
        check("fx_idle_grant", {30'b0, f_grant}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("fx%0d_grant", c), {30'b0, f_grant}, 32'h2);
            check($sformatf("fx%0d_m0_ack", c), {31'b0, f_m0_ack}, 32'h0);
            check($sformatf("fx%0d_m1_ack", c), {31'b0, f_m1_ack}, 32'h1);
            $display("txn fixed cycle %0d grant=%b m1_ack=%b", c, f_grant, f_m1_ack);
        end
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #1;
        check("fx_drop_grant", {30'b0, f_grant}, 32'h2);
        tick();
        check("fx_after_drop_grant", {30'b0, f_grant}, 32'h1);
        s_ack = 1;
        #1;
        check("fx_m0_ack", {31'b0, f_m0_ack}, 32'h1);
        $display("txn fixed handover grant=%b m0_ack=%b", f_grant, f_m0_ack);
        tick();
        clear_inputs();

        // ---- timeout on m1 write, write muxing, watchdog restart ----
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_wstrb = 4'b0011;
        m1_addr = 32'h0000_0100; m1_data_i = 32'h1234_5678;
        m0_addr = 32'h0000_0010; m0_data_i = 32'hAAAA_5555; m0_wstrb = 4'hF;
        tick();
        // first stalled cycle of m1 ownership; m0 starts requesting here
        m0_cyc = 1; m0_stb = 1;
        #1;
        check("wr_grant", {30'b0, grant}, 32'h2);
        check("wr_s_we", {31'b0, s_we}, 32'h1);
        check("wr_s_wstrb", {28'b0, s_wstrb}, 32'h3);
        check("wr_s_data_o", s_data_o, 32'h1234_5678);
        check("wr_s_addr", s_addr, 32'h0000_0100);
        $display("txn m1 write addr=%h data=%h wstrb=%b", s_addr, s_data_o, s_wstrb);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to_stall%0d_err", c), {31'b0, m1_err}, 32'h0);
            check($sformatf("to_stall%0d_stb", c), {31'b0, s_stb}, 32'h1);
            tick();
        end
        check("to_err", {31'b0, m1_err}, 32'h1);
        check("to_err_stb", {31'b0, s_stb}, 32'h0);
        check("to_err_m0_err", {31'b0, m0_err}, 32'h0);
        check("to_err_m1_ack", {31'b0, m1_ack}, 32'h0);
        $display("txn m1 timeout err=%b s_stb=%b", m1_err, s_stb);
        tick();
        check("to_handover_grant", {30'b0, grant}, 32'h1);
        check("to_handover_m1_err", {31'b0, m1_err}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("to_m0_stall%0d_err", c), {31'b0, m0_err}, 32'h0);
            tick();
        end
        check("to_m0_err", {31'b0, m0_err}, 32'h1);
        $display("txn m0 timeout err=%b", m0_err);
        tick();
        clear_inputs();

        // ---- reset during a GNT0 stall ----
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0020;
        tick();
        check("rst_pre_grant", {30'b0, grant}, 32'h1);
        tick();
        reset = 1;
        tick();
        reset = 0;
        m0_cyc = 0; m0_stb = 0;
        s_ack = 1; s_data_i = 32'hCAFE_F00D;
        #1;
        check("rst_grant", {30'b0, grant}, 32'h0);
        check("rst_acks", {30'b0, m0_ack, m1_ack}, 32'h0);
        check("rst_errs", {30'b0, m0_err, m1_err}, 32'h0);
        check("rst_s_cyc_stb", {30'b0, s_cyc, s_stb}, 32'h0);
        check("rst_m0_data", m0_data_o, 32'h0);
        tick();
        s_ack = 0;
        m1_cyc = 1; m1_stb = 1;
        #1;
        check("rst_new_idle", {30'b0, grant}, 32'h0);
        tick();
        check("rst_new_grant", {30'b0, grant}, 32'h2);
        $display("txn reset mid-transfer then m1 grant=%b", grant);
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
Shares one Wishbone-style memory bus between two masters: m0 (instruction fetch) and m1 (data access). It serves the single-memory build, where the core and its data port must reach one Controller bus without ENABLE_SECOND_MEMORY.
- Arbitration is round-robin or fixed-priority.
- The grant is re-evaluated at every transfer termination, so masters that hold cyc permanently high still share the bus.
- A watchdog terminates stalled transfers with an error pulse.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (m1 wins)
TIMEOUT_CYCLES, 255, cycles of stb without ack before a forced err; 0 disables the watchdog

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
m0_cyc, m0_stb, m0_we  in  1 each  master 0 transaction controls
m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes
m0_addr  in  ADDR_WIDTH  master 0 address
m0_data_i  in  DATA_WIDTH  master 0 write data
m0_data_o  out  DATA_WIDTH  read data to master 0
m0_ack, m0_err  out  1 each  master 0 termination signals
m1_*  same set as m0, for master 1
s_cyc, s_stb, s_we  out  1 each  shared slave controls
s_wstrb  out  DATA_WIDTH/8  shared slave byte strobes
s_addr  out  ADDR_WIDTH  shared slave address
s_data_o  out  DATA_WIDTH  write data to the slave
s_data_i  in  DATA_WIDTH  read data from the slave
s_ack  in  1  slave acknowledge
grant  out  2  one-hot owner status: bit0 = m0, bit1 = m1, 00 = idle

Behaviour:
- Request definition: mN is requesting when mN_cyc & mN_stb.
- State machine: IDLE, GNT0, GNT1. Register last_grant resets to 1, so m0 wins the first tie.
- Reset: state goes to IDLE. All outputs are 0: s_*, mN_ack, mN_err, grant. mN_data_o is also 0 in IDLE.
- Reset mid-transfer: the same values apply on the next edge. The in-flight transfer is dropped with no ack and no err.
- IDLE transitions:
  - One requester: go to its GNT state.
  - Both requesting, PRIORITY_MODE=0: grant the master that is not last_grant.
  - Both requesting, PRIORITY_MODE=1: grant m1.
  - Arbitration latency is 1 cycle: the request is seen in IDLE, and s_stb follows in the next cycle.
- GNTn slave drive:
  - s_cyc, s_stb, s_we, s_wstrb, s_addr, s_data_o are combinational copies of mN's signals.
  - mN_ack = s_ack.
  - mN_data_o = s_data_i.
- Non-granted master: ack=0, err=0, data_o=0. It simply waits with stb held.
- Termination: s_ack=1, or a timeout, while in GNTn.
- GNTn transitions on termination (evaluated in the termination cycle):
  - Other master requesting and arbitration picks it (always in RR; in fixed mode only when it has priority): go to GNT_other, last_grant <= n.
  - Otherwise stay in GNTn (back-to-back transfers allowed).
- GNTn with mN_cyc=0: go to GNT_other if it is requesting, else IDLE. Leaving the state updates last_grant.
- Fixed-mode starvation: m0 starvation is allowed by design.
- Watchdog counter (width clog2(TIMEOUT_CYCLES+1)):
  - Increments each GNT cycle with s_stb=1 and s_ack=0.
  - Clears on s_ack, on state change, and on reset.
  - When it equals TIMEOUT_CYCLES: mN_err=1 for exactly one cycle, s_stb is forced 0 in that cycle, and the event counts as termination.
- Ack outside a grant: s_ack while in IDLE, or a late ack, is ignored. No mN_ack is produced.
- Combinational paths: s_ack to mN_ack exists. There is no combinational path from mN_* to grant; grant is registered.

Decomposition:
- Package wb_arbiter_pkg:
  - State enum arb_state_t {IDLE, GNT0, GNT1}.
  - PRIO_RR / PRIO_FIXED constants.
  - Function next_grant(req0, req1, last_grant, mode).
- Sub-module wb_timeout_counter: enable/clear in, expired out. It is parameterised by TIMEOUT_CYCLES and outputs constant 0 when TIMEOUT_CYCLES = 0.
- The top holds the FSM and the output muxing.

Test Plan:
- Reset then m0 reads 0x0000_0010, slave acks 1 cycle later with 0xDEAD_BEEF -> grant=01 one cycle after the request; m0_data_o=0xDEAD_BEEF with m0_ack=1; m1_ack stays 0.
- RR mode, both masters hold cyc=stb=1 continuously, slave acks every cycle -> grant sequence 01,10,01,10…; strict alternation of acks.
- PRIORITY_MODE=1, both requesting continuously -> grant stays 10 and m0 gets no ack. After m1 drops cyc -> grant=01 next cycle.
- TIMEOUT_CYCLES=4, m1 writes to 0x0000_0100 and the slave never acks -> m1_err=1 exactly on the 4th stalled cycle with s_stb=0 that cycle; the counter restarts; a pending m0 request gets grant=01 next cycle.
- reset asserted during a GNT0 stall, s_ack pulsed the cycle after reset -> all outputs 0, grant=00, no mN_ack; a new m1 request after reset gets grant=10.
- m1 write 0x1234_5678 with wstrb=0011 -> s_we=1, s_wstrb=0011, s_data_o=0x1234_5678 when grant=10; m0 signals are not visible on the s_* outputs.
